// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI constants, message kinds and parser state encoding for the voice allocator.
// Latency: n/a. Backpressure: n/a.
package midi_voice_allocator_pkg;

    localparam logic [3:0] STATUS_NOTE_OFF  = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON   = 4'h9;
    localparam logic [3:0] STATUS_CC        = 4'hB;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

    typedef enum logic [1:0] {
        NOTE_OFF,
        NOTE_ON,
        CC,
        OTHER
    } msg_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2
    } parse_state_t;

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status; msg_valid is combinational in the cycle the second data byte arrives.
// Backpressure: none, one byte consumed per cycle while midi_valid is high.
module midi_byte_parser
    import midi_voice_allocator_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_data,
    input  logic       midi_valid,
    output logic       msg_valid,
    output msg_kind_t  msg_kind,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2
);

    parse_state_t state_q, state_d;
    msg_kind_t    kind_q, kind_d;
    logic [6:0]   d1_q, d1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= OTHER;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            d1_q    <= d1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        d1_d      = d1_q;
        msg_valid = 1'b0;
        msg_kind  = kind_q;
        msg_d1    = d1_q;
        msg_d2    = midi_data[6:0];
        // Realtime bytes (F8-FF) fall through untouched so they can interleave anywhere.
        if (midi_valid && (midi_data < 8'hF8)) begin
            if (midi_data >= 8'hF0) begin
                kind_d  = OTHER;
                state_d = ST_IDLE;
            end else if (midi_data[7]) begin
                state_d = ST_DATA1;
                if (midi_data[3:0] != 4'(CHANNEL)) begin
                    kind_d = OTHER;
                end else begin
                    case (midi_data[7:4])
                        STATUS_NOTE_OFF: kind_d = NOTE_OFF;
                        STATUS_NOTE_ON:  kind_d = NOTE_ON;
                        STATUS_CC:       kind_d = CC;
                        default:         kind_d = OTHER;
                    endcase
                end
            end else begin
                case (state_q)
                    ST_DATA1: begin
                        d1_d    = midi_data[6:0];
                        state_d = ST_DATA2;
                    end
                    ST_DATA2: begin
                        msg_valid = (kind_q != OTHER);
                        state_d   = ST_DATA1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: MIDI note on/off to NUM_VOICES slots, free-first then LRU steal; outputs 1 cycle after the last byte.
// Backpressure: none, one byte consumed per cycle while midi_valid is high.
module midi_voice_allocator
    import midi_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int VOICE_IDX_BITS = 2,
    parameter int CHANNEL        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                midi_data,
    input  logic                      midi_valid,
    output logic [NUM_VOICES*7-1:0]   voice_note,
    output logic [NUM_VOICES*7-1:0]   voice_velocity,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trigger,
    output logic                      steal
);

    logic       msg_valid;
    msg_kind_t  msg_kind;
    logic [6:0] msg_d1, msg_d2;

    midi_byte_parser #(.CHANNEL(CHANNEL)) u_parser (
        .clk        (clk),
        .rst        (rst),
        .midi_data  (midi_data),
        .midi_valid (midi_valid),
        .msg_valid  (msg_valid),
        .msg_kind   (msg_kind),
        .msg_d1     (msg_d1),
        .msg_d2     (msg_d2)
    );

    logic [6:0]                note_q [NUM_VOICES];
    logic [6:0]                vel_q  [NUM_VOICES];
    logic [VOICE_IDX_BITS-1:0] rank_q [NUM_VOICES];
    logic [NUM_VOICES-1:0]     gate_q, trigger_q;
    logic                      steal_q;

    logic [NUM_VOICES-1:0]     match_vec;
    logic                      match_found, free_found;
    logic [VOICE_IDX_BITS-1:0] match_idx, free_idx, oldest_idx, alloc_idx;
    logic                      do_alloc, do_release, do_all_off;

    assign do_alloc   = msg_valid && (msg_kind == NOTE_ON) && (msg_d2 != 7'd0);
    assign do_release = msg_valid && ((msg_kind == NOTE_OFF) ||
                                      ((msg_kind == NOTE_ON) && (msg_d2 == 7'd0)));
    assign do_all_off = msg_valid && (msg_kind == CC) &&
                        ((msg_d1 == CC_ALL_NOTES_OFF) || (msg_d1 == CC_ALL_SOUND_OFF));

    // Descending scans so the lowest matching index wins.
    always_comb begin
        match_vec   = '0;
        match_found = 1'b0;
        free_found  = 1'b0;
        match_idx   = '0;
        free_idx    = '0;
        oldest_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match_vec[i] = gate_q[i] && (note_q[i] == msg_d1);
            if (match_vec[i]) begin
                match_found = 1'b1;
                match_idx   = VOICE_IDX_BITS'(i);
            end
            if (!gate_q[i]) begin
                free_found = 1'b1;
                free_idx   = VOICE_IDX_BITS'(i);
            end
            if (rank_q[i] == VOICE_IDX_BITS'(NUM_VOICES - 1)) begin
                oldest_idx = VOICE_IDX_BITS'(i);
            end
        end
        alloc_idx = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= VOICE_IDX_BITS'(NUM_VOICES - 1 - i);
            end
            gate_q    <= '0;
            trigger_q <= '0;
            steal_q   <= 1'b0;
        end else begin
            trigger_q <= '0;
            steal_q   <= 1'b0;
            if (do_alloc) begin
                note_q[alloc_idx]    <= msg_d1;
                vel_q[alloc_idx]     <= msg_d2;
                gate_q[alloc_idx]    <= 1'b1;
                trigger_q[alloc_idx] <= 1'b1;
                steal_q              <= !match_found && !free_found;
                // Younger-than-chosen voices age by one; ranks stay a permutation.
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (VOICE_IDX_BITS'(i) == alloc_idx) begin
                        rank_q[i] <= '0;
                    end else if (rank_q[i] < rank_q[alloc_idx]) begin
                        rank_q[i] <= rank_q[i] + VOICE_IDX_BITS'(1);
                    end
                end
            end else if (do_release) begin
                gate_q <= gate_q & ~match_vec;
            end else if (do_all_off) begin
                gate_q <= '0;
            end
        end
    end

    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[7*i +: 7]     = note_q[i];
            voice_velocity[7*i +: 7] = vel_q[i];
        end
    end

    assign voice_gate    = gate_q;
    assign voice_trigger = trigger_q;
    assign steal         = steal_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (4 voices, channel 0).
module tb_midi_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  midi_data = 8'h00;
    logic        midi_valid = 1'b0;
    logic [27:0] voice_note;
    logic [27:0] voice_velocity;
    logic [3:0]  voice_gate;
    logic [3:0]  voice_trigger;
    logic        steal;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    midi_voice_allocator #(
        .NUM_VOICES     (4),
        .VOICE_IDX_BITS (2),
        .CHANNEL        (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .midi_data      (midi_data),
        .midi_valid     (midi_valid),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_gate     (voice_gate),
        .voice_trigger  (voice_trigger),
        .steal          (steal)
    );

    // Drive one byte for one cycle; returns #1 after the consuming edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        midi_data  = b;
        midi_valid = 1'b1;
        @(posedge clk);
        #1;
        midi_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        midi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (voice_note !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_note: got %h want %h", voice_note, 28'h0);
        end
        tests_run++;
        if (voice_velocity !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_vel: got %h want %h", voice_velocity, 28'h0);
        end
        tests_run++;
        if ({voice_gate, voice_trigger, steal} !== 9'h0) begin
            tests_failed++;
            $display("FAIL reset_ctl: gate %b trig %b steal %b want all 0", voice_gate, voice_trigger, steal);
        end
    endtask

    task automatic test_single_note_on();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        tests_run++;
        if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin
            tests_failed++;
            $display("FAIL single_v0: note %0d vel %0d want 60 100", voice_note[6:0], voice_velocity[6:0]);
        end
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0001 || steal !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ctl: gate %b trig %b steal %b want 0001 0001 0", voice_gate, voice_trigger, steal);
        end
        @(posedge clk); #1;
        tests_run++;
        if (voice_trigger !== 4'b0000 || voice_gate !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_pulse: trig %b gate %b want 0000 0001", voice_trigger, voice_gate);
        end
    endtask

    task automatic test_running_status();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
        tests_run++;
        if (voice_note[13:7] !== 7'd64 || voice_velocity[13:7] !== 7'd80 || voice_note[6:0] !== 7'd60) begin
            tests_failed++;
            $display("FAIL running_notes: v0 %0d v1 %0d vel1 %0d want 60 64 80",
                     voice_note[6:0], voice_note[13:7], voice_velocity[13:7]);
        end
        tests_run++;
        if (voice_gate !== 4'b0011 || voice_trigger !== 4'b0010) begin
            tests_failed++;
            $display("FAIL running_ctl: gate %b trig %b want 0011 0010", voice_gate, voice_trigger);
        end
    endtask

    task automatic test_steal();
        do_reset();
        send(8'h90);
        send(8'h3C); send(8'h64);
        send(8'h3E); send(8'h64);
        send(8'h40); send(8'h64);
        send(8'h41); send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b1111 || steal !== 1'b0) begin
            tests_failed++;
            $display("FAIL steal_fill: gate %b steal %b want 1111 0", voice_gate, steal);
        end
        send(8'h43); send(8'h64);
        tests_run++;
        if (steal !== 1'b1 || voice_trigger !== 4'b0001 || voice_note[6:0] !== 7'd67) begin
            tests_failed++;
            $display("FAIL steal_v0: steal %b trig %b note0 %0d want 1 0001 67", steal, voice_trigger, voice_note[6:0]);
        end
        // Voice 0 is now newest, so the next steal must take voice 1.
        send(8'h45); send(8'h64);
        tests_run++;
        if (steal !== 1'b1 || voice_trigger !== 4'b0010 || voice_note[13:7] !== 7'd69 || voice_note[6:0] !== 7'd67) begin
            tests_failed++;
            $display("FAIL steal_v1: steal %b trig %b note1 %0d note0 %0d want 1 0010 69 67",
                     steal, voice_trigger, voice_note[13:7], voice_note[6:0]);
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h3C); send(8'h70);
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0001 || steal !== 1'b0 || voice_velocity[6:0] !== 7'h70) begin
            tests_failed++;
            $display("FAIL duplicate: gate %b trig %b steal %b vel0 %h want 0001 0001 0 70",
                     voice_gate, voice_trigger, steal, voice_velocity[6:0]);
        end
    endtask

    task automatic test_note_off();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h00);
        tests_run++;
        if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'd60 || voice_trigger !== 4'b0000) begin
            tests_failed++;
            $display("FAIL off_vel0: gate %b note0 %0d trig %b want 0000 60 0000", voice_gate, voice_note[6:0], voice_trigger);
        end
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h80); send(8'h3C); send(8'h00);
        tests_run++;
        if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin
            tests_failed++;
            $display("FAIL off_8x: gate %b note0 %0d vel0 %0d want 0000 60 100", voice_gate, voice_note[6:0], voice_velocity[6:0]);
        end
    endtask

    task automatic test_filter();
        do_reset();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd60 || voice_trigger !== 4'b0001) begin
            tests_failed++;
            $display("FAIL filter_rt: gate %b note0 %0d trig %b want 0001 60 0001", voice_gate, voice_note[6:0], voice_trigger);
        end
        send(8'hF0); send(8'h40); send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_note[13:7] !== 7'd0) begin
            tests_failed++;
            $display("FAIL filter_sysex: gate %b note1 %0d want 0001 0", voice_gate, voice_note[13:7]);
        end
        send(8'h91); send(8'h40); send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0000 || voice_note[13:7] !== 7'd0) begin
            tests_failed++;
            $display("FAIL filter_chan: gate %b trig %b note1 %0d want 0001 0000 0", voice_gate, voice_trigger, voice_note[13:7]);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h90); send(8'h3E); send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd62) begin
            tests_failed++;
            $display("FAIL abandon: gate %b note0 %0d want 0001 62", voice_gate, voice_note[6:0]);
        end
    endtask

    task automatic test_all_notes_off();
        do_reset();
        send(8'h90);
        send(8'h3C); send(8'h64);
        send(8'h3E); send(8'h64);
        send(8'h40); send(8'h64);
        send(8'h41); send(8'h64);
        send(8'hB0); send(8'h7B); send(8'h00);
        tests_run++;
        if (voice_gate !== 4'b0000 || voice_note[27:21] !== 7'd65) begin
            tests_failed++;
            $display("FAIL all_off_123: gate %b note3 %0d want 0000 65", voice_gate, voice_note[27:21]);
        end
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'hB0); send(8'h07); send(8'h00);
        tests_run++;
        if (voice_gate !== 4'b0001) begin
            tests_failed++;
            $display("FAIL cc_other: gate %b want 0001", voice_gate);
        end
        send(8'hB0); send(8'h78); send(8'h00);
        tests_run++;
        if (voice_gate !== 4'b0000) begin
            tests_failed++;
            $display("FAIL all_off_120: gate %b want 0000", voice_gate);
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        tests_run++;
        if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000 || voice_note !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: gate %b trig %b note %h want 0000 0000 0", voice_gate, voice_trigger, voice_note);
        end
    endtask

    initial begin
        test_reset();
        test_single_note_on();
        test_running_status();
        test_steal();
        test_duplicate();
        test_note_off();
        test_filter();
        test_abandon();
        test_all_notes_off();
        test_reset_mid_message();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
